fetch_controller: RTL

Instruction-fetch sequencer that reads the address held by the PC register and issues it to a handshaked, variable-latency instruction memory. It returns the fetched instruction to the IF/ID stage and drives the PC register's enable and next-value inputs. It handles back-pressure from decode and control-flow redirects, including discarding stale in-flight responses. At most one memory request is outstanding at a time.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_perf_counter.sv | 29 ++
 rtl/fetch_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encodings,
// the PC register reset value and the default sequential PC step.
package fetch_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [31:0] RESET_PC        = 32'h0040_0000;
  localparam int unsigned PC_STEP_DEFAULT = 32'd4;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter; used for the optional fetch performance
// counters of fetch_controller.
module fetch_perf_counter
  import fetch_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: one outstanding request to a handshaked
// variable-latency memory. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_value,
  output logic         pc_enable,
  output logic [N-1:0] next_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         id_stall,
  output logic         if_valid,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [N-1:0] perf_fetch_cnt,
  output logic [N-1:0] perf_stall_cnt
`endif
);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic         w_capture;
  logic         w_release;
  logic         r_if_valid;
  logic [N-1:0] r_if_instr;
  logic [N-1:0] r_if_pc;

  assign imem_addr      = {pc_value[N-1:2], 2'b00};
  assign next_pc        = redirect_valid ? redirect_pc : (pc_value + N'(PC_STEP));
  // a redirect always advances the PC, whatever the state; HOLD also advances on consume
  assign imem_req_valid = reset & (r_state == S_REQ) & ~redirect_valid;
  assign pc_enable      = reset & (redirect_valid | ((r_state == S_HOLD) & ~id_stall));

  // next-state decode plus capture/release strobes for the IF/ID register
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = S_REQ;
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          w_state_nxt = S_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect_valid || !id_stall) begin
          w_state_nxt = S_REQ;
          w_release   = 1'b1;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IF/ID output register: loads on an accepted response, stays stable while held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else if (w_capture) begin
      r_if_valid <= 1'b1;
      r_if_instr <= imem_rsp_data;
      r_if_pc    <= imem_addr;
    end else if (w_release) begin
      r_if_valid <= 1'b0;
      r_if_instr <= r_if_instr;
      r_if_pc    <= r_if_pc;
    end else begin
      r_if_valid <= r_if_valid;
      r_if_instr <= r_if_instr;
      r_if_pc    <= r_if_pc;
    end
  end

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;

`ifdef FETCH_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = (r_state == S_HOLD) & ~id_stall & ~redirect_valid;
  assign w_stall_inc = (r_state != S_HOLD);

  fetch_perf_counter #(.W(N)) u_fetch_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_fetch_inc),
    .o_count (perf_fetch_cnt)
  );

  fetch_perf_counter #(.W(N)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (perf_stall_cnt)
  );
`endif

endmodule
